// File: rtl/opr_seq_decoder.sv
// Instruction sequencer: decodes an accepted opcode into registered unit selects,
// then times execution by a fixed delay or by a variable-latency unit handshake.
module opr_seq_decoder #(
  parameter int OPR_W      = 5,
  parameter int DST_W      = 8,
  parameter int DLY_W      = 8,
  parameter int ALU_TYP_W  = 4,
  parameter int PRNG_TYP_W = 2,
  parameter int SPRF_N     = 2,
  parameter int SPRF_BASE  = 32,
  parameter int TMO_W      = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [OPR_W-1:0]        opr_code,
  input  logic [DST_W-1:0]        dst_code,
  input  logic [2:0]              src_typ,
  input  logic [2:0]              dst_typ,
  input  logic                    unit_done,
  output logic [OPR_W-1:0]        opr_typ_sel,
  output logic                    opr_div_mod_sel,
  output logic                    alu_o_sel,
  output logic                    alu_t_sel,
  output logic [ALU_TYP_W-1:0]    alu_typ_sel,
  output logic                    prng_t_sel,
  output logic [PRNG_TYP_W-1:0]   prng_typ_sel,
  output logic [2*SPRF_N-1:0]     sprf_typ_sel,
  output logic                    exec_busy,
  output logic                    exec_done,
  output logic                    illegal,
  output logic                    timeout
);

  localparam logic [OPR_W-1:0] OP_MOV    = OPR_W'(1);
  localparam logic [OPR_W-1:0] OP_ADD    = OPR_W'(2);
  localparam logic [OPR_W-1:0] OP_SUB    = OPR_W'(3);
  localparam logic [OPR_W-1:0] OP_MUL    = OPR_W'(4);
  localparam logic [OPR_W-1:0] OP_DIV    = OPR_W'(5);
  localparam logic [OPR_W-1:0] OP_PRNG   = OPR_W'(6);
  localparam logic [OPR_W-1:0] OP_IDX    = OPR_W'(7);
  localparam logic [OPR_W-1:0] OP_INV    = OPR_W'(8);
  localparam logic [OPR_W-1:0] OP_SPLIT  = OPR_W'(9);
  localparam logic [OPR_W-1:0] OP_DEG    = OPR_W'(10);
  localparam logic [OPR_W-1:0] OP_RSHIFT = OPR_W'(11);
  localparam logic [OPR_W-1:0] OP_EVAL   = OPR_W'(12);
  localparam logic [OPR_W-1:0] OP_JMP    = OPR_W'(16);
  localparam logic [OPR_W-1:0] OP_JRE    = OPR_W'(17);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [DLY_W-1:0]        dly_q, dly_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic                    tmo_expire;

  logic [OPR_W-1:0]        opr_typ_q;
  logic                    div_mod_q, alu_o_q, alu_t_q, prng_t_q;
  logic [ALU_TYP_W-1:0]    alu_typ_q;
  logic [PRNG_TYP_W-1:0]   prng_typ_q;
  logic [2*SPRF_N-1:0]     sprf_q;
  logic                    illegal_q, timeout_q;

  logic                    dec_legal, dec_var, dec_alu_en, dec_prng_t, dec_div_mod;
  logic [DLY_W-1:0]        dec_dly;
  logic [ALU_TYP_W-1:0]    dec_alu_typ;
  logic [PRNG_TYP_W-1:0]   dec_prng_typ;
  logic [1:0]              dec_sprf_code;
  logic [2*SPRF_N-1:0]     dec_sprf;
  logic                    accept, start;
  logic                    unused_dst_hi;

  assign unused_dst_hi = ^dst_code[DST_W-1:5];

  always_comb begin
    dec_legal     = 1'b0;
    dec_var       = 1'b0;
    dec_dly       = '0;
    dec_alu_en    = 1'b0;
    dec_alu_typ   = '0;
    dec_prng_t    = 1'b0;
    dec_prng_typ  = '0;
    dec_div_mod   = 1'b0;
    dec_sprf_code = 2'd0;
    unique case (opr_code)
      OP_MOV: begin
        unique case ({src_typ, dst_typ})
          6'b101_000, 6'b101_100: begin dec_legal = 1'b1; dec_dly = DLY_W'(6); end
          6'b010_000, 6'b000_100: begin dec_legal = 1'b1; dec_dly = DLY_W'(1); end
          6'b000_000: begin dec_legal = 1'b1; dec_dly = DLY_W'(1); dec_sprf_code = 2'd1; end
          6'b000_101: begin dec_legal = 1'b1; dec_dly = DLY_W'(2); end
          default: ;
        endcase
      end
      OP_ADD:    begin dec_legal = 1'b1; dec_alu_en = 1'b1; dec_alu_typ = ALU_TYP_W'(1); dec_dly = DLY_W'(4); end
      OP_SUB:    begin dec_legal = 1'b1; dec_alu_en = 1'b1; dec_alu_typ = ALU_TYP_W'(2); dec_dly = DLY_W'(4); end
      OP_MUL:    begin dec_legal = 1'b1; dec_alu_en = 1'b1; dec_alu_typ = ALU_TYP_W'(3); dec_var = 1'b1; end
      OP_DIV: begin
        dec_legal = 1'b1; dec_alu_en = 1'b1; dec_alu_typ = ALU_TYP_W'(5); dec_var = 1'b1;
        dec_div_mod = (src_typ == 3'b100);
      end
      OP_INV:    begin dec_legal = 1'b1; dec_alu_en = 1'b1; dec_alu_typ = ALU_TYP_W'(6); dec_dly = DLY_W'(21); end
      OP_SPLIT:  begin dec_legal = 1'b1; dec_alu_en = 1'b1; dec_alu_typ = ALU_TYP_W'(2); dec_var = 1'b1; end
      OP_DEG:    begin dec_legal = 1'b1; dec_alu_en = 1'b1; dec_alu_typ = ALU_TYP_W'(7); dec_var = 1'b1; end
      OP_RSHIFT: begin dec_legal = 1'b1; dec_alu_en = 1'b1; dec_alu_typ = ALU_TYP_W'(8); dec_var = 1'b1; end
      OP_EVAL: begin
        dec_legal = 1'b1; dec_alu_en = 1'b1; dec_alu_typ = ALU_TYP_W'(9); dec_dly = DLY_W'(23);
        dec_div_mod = (src_typ == 3'b100);
      end
      OP_JRE:    begin dec_legal = 1'b1; dec_alu_en = 1'b1; dec_alu_typ = ALU_TYP_W'(4); dec_dly = DLY_W'(7); end
      OP_JMP:    begin dec_legal = 1'b1; dec_dly = DLY_W'(3); end
      OP_PRNG: begin
        if ({src_typ, dst_typ} == 6'b010_000) begin
          dec_legal = 1'b1; dec_prng_t = 1'b1; dec_prng_typ = PRNG_TYP_W'(2); dec_dly = DLY_W'(3);
        end else if ({src_typ, dst_typ} == 6'b000_000) begin
          dec_legal = 1'b1; dec_prng_typ = PRNG_TYP_W'(1); dec_dly = DLY_W'(4);
        end
      end
      OP_IDX: begin
        if (dst_typ == 3'b000) begin
          dec_legal = 1'b1; dec_dly = DLY_W'(2); dec_sprf_code = 2'd2;
        end else if (dst_typ == 3'b001) begin
          dec_legal = 1'b1; dec_dly = DLY_W'(2); dec_sprf_code = 2'd3;
        end
      end
      default: ;
    endcase
  end

  // Only the slot whose address matches the low destination bits takes the code.
  generate
    for (genvar gi = 0; gi < SPRF_N; gi++) begin : g_sprf
      localparam logic [4:0] SPRF_ADDR = 5'(SPRF_BASE + gi);
      assign dec_sprf[2*gi +: 2] = (dst_code[4:0] == SPRF_ADDR) ? dec_sprf_code : 2'd0;
    end
  endgenerate

  assign instr_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept      = instr_valid & instr_ready;
  assign start       = accept & dec_legal;

  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    tmo_d      = tmo_q;
    tmo_expire = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          if (dec_var) begin
            state_d = S_WAIT;
            tmo_d   = TMO_W'(1);
          end else begin
            state_d = S_EXEC;
            dly_d   = dec_dly;
          end
        end
      end
      S_EXEC: begin
        dly_d = dly_q - DLY_W'(1);
        if (dly_q <= DLY_W'(1)) state_d = S_DONE;
      end
      S_WAIT: begin
        // A completion arriving on the last timeout cycle wins over the timeout.
        if (unit_done) begin
          state_d = S_DONE;
          tmo_d   = '0;
        end else if (&tmo_q) begin
          state_d    = S_DONE;
          tmo_d      = '0;
          tmo_expire = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dly_q      <= '0;
      tmo_q      <= '0;
      opr_typ_q  <= '0;
      div_mod_q  <= 1'b0;
      alu_o_q    <= 1'b0;
      alu_t_q    <= 1'b0;
      alu_typ_q  <= '0;
      prng_t_q   <= 1'b0;
      prng_typ_q <= '0;
      sprf_q     <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      tmo_q     <= tmo_d;
      illegal_q <= accept & ~dec_legal;
      timeout_q <= tmo_expire;
      if (start) begin
        opr_typ_q  <= opr_code;
        div_mod_q  <= dec_div_mod;
        alu_o_q    <= dec_alu_en;
        alu_t_q    <= dec_alu_en;
        alu_typ_q  <= dec_alu_typ;
        prng_t_q   <= dec_prng_t;
        prng_typ_q <= dec_prng_typ;
        sprf_q     <= dec_sprf;
      end else if (state_d == S_IDLE && state_q != S_IDLE) begin
        // Type codes stay visible in IDLE; enables drop.
        div_mod_q <= 1'b0;
        alu_o_q   <= 1'b0;
        alu_t_q   <= 1'b0;
        prng_t_q  <= 1'b0;
        sprf_q    <= '0;
      end
    end
  end

  assign opr_typ_sel     = opr_typ_q;
  assign opr_div_mod_sel = div_mod_q;
  assign alu_o_sel       = alu_o_q;
  assign alu_t_sel       = alu_t_q;
  assign alu_typ_sel     = alu_typ_q;
  assign prng_t_sel      = prng_t_q;
  assign prng_typ_sel    = prng_typ_q;
  assign sprf_typ_sel    = sprf_q;
  assign exec_busy       = (state_q == S_EXEC) || (state_q == S_WAIT);
  assign exec_done       = (state_q == S_DONE);
  assign illegal         = illegal_q;
  assign timeout         = timeout_q;

endmodule

// File: tb/tb_opr_seq_decoder.sv
// Directed bench for opr_seq_decoder: inputs driven and outputs sampled on the
// falling edge, expected values hand-computed per scenario.
module tb_opr_seq_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid, instr_ready;
  logic [4:0] opr_code;
  logic [7:0] dst_code;
  logic [2:0] src_typ, dst_typ;
  logic       unit_done;
  logic [4:0] opr_typ_sel;
  logic       opr_div_mod_sel, alu_o_sel, alu_t_sel, prng_t_sel;
  logic [3:0] alu_typ_sel;
  logic [1:0] prng_typ_sel;
  logic [3:0] sprf_typ_sel;
  logic       exec_busy, exec_done, illegal, timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  opr_seq_decoder dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opr_code(opr_code), .dst_code(dst_code),
    .src_typ(src_typ), .dst_typ(dst_typ), .unit_done(unit_done),
    .opr_typ_sel(opr_typ_sel), .opr_div_mod_sel(opr_div_mod_sel),
    .alu_o_sel(alu_o_sel), .alu_t_sel(alu_t_sel), .alu_typ_sel(alu_typ_sel),
    .prng_t_sel(prng_t_sel), .prng_typ_sel(prng_typ_sel), .sprf_typ_sel(sprf_typ_sel),
    .exec_busy(exec_busy), .exec_done(exec_done), .illegal(illegal), .timeout(timeout)
  );

  // Waits for ready, presents one instruction for one edge; returns in cycle T+1.
  task automatic send(input logic [4:0] op, input logic [2:0] st, input logic [2:0] dt,
                      input logic [7:0] dc);
    int n = 0;
    while (!instr_ready && n < 50) begin @(negedge clk); n++; end
    total++;
    if (instr_ready !== 1'b1) begin bad++; $display("FAIL send_ready got=%b exp=1", instr_ready); end
    opr_code = op; src_typ = st; dst_typ = dt; dst_code = dc; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    $display("txn op=%0d src=%03b dst=%03b code=%0d", op, st, dt, dc);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (exec_busy && n < 100) begin n++; @(negedge clk); end
  endtask

  task automatic test_reset;
    rst = 1'b1; instr_valid = 1'b0; unit_done = 1'b0;
    opr_code = '0; dst_code = '0; src_typ = '0; dst_typ = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", instr_ready); end
    total++; if ({exec_busy, exec_done, illegal, timeout} !== 4'b0) begin
      bad++; $display("FAIL rst_status got=%b exp=0000", {exec_busy, exec_done, illegal, timeout}); end
    total++; if ({opr_typ_sel, alu_typ_sel, prng_typ_sel, sprf_typ_sel} !== 15'd0) begin
      bad++; $display("FAIL rst_types got=%h exp=0", {opr_typ_sel, alu_typ_sel, prng_typ_sel, sprf_typ_sel}); end
    total++; if ({opr_div_mod_sel, alu_o_sel, alu_t_sel, prng_t_sel} !== 4'b0) begin
      bad++; $display("FAIL rst_enables got=%b exp=0000", {opr_div_mod_sel, alu_o_sel, alu_t_sel, prng_t_sel}); end
  endtask

  task automatic test_add;
    int n;
    send(5'd2, 3'b000, 3'b000, 8'd0);
    total++; if ({alu_o_sel, alu_t_sel, alu_typ_sel, opr_typ_sel} !== {2'b11, 4'd1, 5'd2}) begin
      bad++; $display("FAIL add_sel got=%b/%b/%0d/%0d exp=1/1/1/2", alu_o_sel, alu_t_sel, alu_typ_sel, opr_typ_sel); end
    total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL add_ready_busy got=%b exp=0", instr_ready); end
    count_busy(n);
    total++; if (n !== 4) begin bad++; $display("FAIL add_busy_len got=%0d exp=4", n); end
    total++; if ({exec_done, instr_ready} !== 2'b11) begin
      bad++; $display("FAIL add_done got=%b exp=11", {exec_done, instr_ready}); end
    @(negedge clk);
    total++; if ({exec_done, alu_o_sel, alu_t_sel, alu_typ_sel} !== {3'b000, 4'd1}) begin
      bad++; $display("FAIL add_idle got=%b/%b/%b/%0d exp=0/0/0/1", exec_done, alu_o_sel, alu_t_sel, alu_typ_sel); end
  endtask

  task automatic test_mov_sprf;
    int n;
    send(5'd1, 3'b000, 3'b000, 8'd33);
    total++; if (sprf_typ_sel !== 4'b0100) begin bad++; $display("FAIL mov_sprf got=%b exp=0100", sprf_typ_sel); end
    count_busy(n);
    total++; if (n !== 1) begin bad++; $display("FAIL mov_busy_len got=%0d exp=1", n); end
    total++; if ({exec_done, sprf_typ_sel} !== 5'b1_0100) begin
      bad++; $display("FAIL mov_done_hold got=%b exp=10100", {exec_done, sprf_typ_sel}); end
    @(negedge clk);
    total++; if (sprf_typ_sel !== 4'b0000) begin bad++; $display("FAIL mov_idle_sprf got=%b exp=0000", sprf_typ_sel); end
    send(5'd1, 3'b101, 3'b100, 8'd0);
    count_busy(n);
    total++; if (n !== 6) begin bad++; $display("FAIL mov101_busy_len got=%0d exp=6", n); end
    @(negedge clk);
  endtask

  task automatic test_idx;
    int n;
    send(5'd7, 3'b000, 3'b001, 8'd32);
    total++; if ({sprf_typ_sel, opr_typ_sel} !== {4'b0011, 5'd7}) begin
      bad++; $display("FAIL idx_sel got=%b/%0d exp=0011/7", sprf_typ_sel, opr_typ_sel); end
    count_busy(n);
    total++; if (n !== 2) begin bad++; $display("FAIL idx_busy_len got=%0d exp=2", n); end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    send(5'd13, 3'b000, 3'b000, 8'd0);
    total++; if ({illegal, exec_busy, opr_typ_sel} !== {2'b10, 5'd7}) begin
      bad++; $display("FAIL ill_op13 got=%b/%b/%0d exp=1/0/7", illegal, exec_busy, opr_typ_sel); end
    @(negedge clk);
    total++; if ({illegal, instr_ready} !== 2'b01) begin
      bad++; $display("FAIL ill_pulse got=%b exp=01", {illegal, instr_ready}); end
    send(5'd6, 3'b000, 3'b010, 8'd0);
    total++; if ({illegal, exec_busy, opr_typ_sel, prng_typ_sel} !== {2'b10, 5'd7, 2'd0}) begin
      bad++; $display("FAIL ill_prng got=%b/%b/%0d/%0d exp=1/0/7/0", illegal, exec_busy, opr_typ_sel, prng_typ_sel); end
    @(negedge clk);
  endtask

  task automatic test_prng;
    int n;
    send(5'd6, 3'b010, 3'b000, 8'd0);
    total++; if ({prng_t_sel, prng_typ_sel, alu_o_sel} !== {1'b1, 2'd2, 1'b0}) begin
      bad++; $display("FAIL prng_t_sel got=%b/%0d/%b exp=1/2/0", prng_t_sel, prng_typ_sel, alu_o_sel); end
    count_busy(n);
    total++; if (n !== 3) begin bad++; $display("FAIL prng_t_len got=%0d exp=3", n); end
    @(negedge clk);
    total++; if ({prng_t_sel, prng_typ_sel} !== {1'b0, 2'd2}) begin
      bad++; $display("FAIL prng_idle got=%b/%0d exp=0/2", prng_t_sel, prng_typ_sel); end
    send(5'd6, 3'b000, 3'b000, 8'd0);
    total++; if ({prng_t_sel, prng_typ_sel} !== {1'b0, 2'd1}) begin
      bad++; $display("FAIL prng_plain got=%b/%0d exp=0/1", prng_t_sel, prng_typ_sel); end
    count_busy(n);
    total++; if (n !== 4) begin bad++; $display("FAIL prng_plain_len got=%0d exp=4", n); end
    @(negedge clk);
  endtask

  task automatic test_div;
    send(5'd5, 3'b100, 3'b000, 8'd0);
    total++; if ({opr_div_mod_sel, alu_typ_sel, exec_busy} !== {1'b1, 4'd5, 1'b1}) begin
      bad++; $display("FAIL div_sel got=%b/%0d/%b exp=1/5/1", opr_div_mod_sel, alu_typ_sel, exec_busy); end
    unit_done = 1'b1;
    @(negedge clk);
    unit_done = 1'b0;
    total++; if ({exec_done, exec_busy, timeout} !== 3'b100) begin
      bad++; $display("FAIL div_done got=%b exp=100", {exec_done, exec_busy, timeout}); end
    @(negedge clk);
    total++; if ({opr_div_mod_sel, alu_typ_sel} !== {1'b0, 4'd5}) begin
      bad++; $display("FAIL div_idle got=%b/%0d exp=0/5", opr_div_mod_sel, alu_typ_sel); end
  endtask

  task automatic test_mul_done;
    // unit_done while idle must not start anything
    unit_done = 1'b1;
    @(negedge clk);
    unit_done = 1'b0;
    total++; if ({exec_busy, exec_done} !== 2'b00) begin
      bad++; $display("FAIL idle_unit_done got=%b exp=00", {exec_busy, exec_done}); end
    send(5'd4, 3'b000, 3'b000, 8'd0);
    repeat (9) @(negedge clk);
    unit_done = 1'b1;
    total++; if ({exec_busy, exec_done, alu_typ_sel} !== {2'b10, 4'd3}) begin
      bad++; $display("FAIL mul_wait got=%b/%b/%0d exp=1/0/3", exec_busy, exec_done, alu_typ_sel); end
    @(negedge clk);
    unit_done = 1'b0;
    total++; if ({exec_done, timeout} !== 2'b10) begin
      bad++; $display("FAIL mul_done got=%b exp=10", {exec_done, timeout}); end
    @(negedge clk);
  endtask

  task automatic test_mul_timeout;
    send(5'd4, 3'b000, 3'b000, 8'd0);
    repeat (4094) @(negedge clk);
    total++; if ({exec_busy, exec_done, timeout} !== 3'b100) begin
      bad++; $display("FAIL tmo_before got=%b exp=100", {exec_busy, exec_done, timeout}); end
    @(negedge clk);
    total++; if ({exec_done, timeout} !== 2'b11) begin
      bad++; $display("FAIL tmo_pulse got=%b exp=11", {exec_done, timeout}); end
    @(negedge clk);
    total++; if ({exec_done, timeout} !== 2'b00) begin
      bad++; $display("FAIL tmo_clear got=%b exp=00", {exec_done, timeout}); end
  endtask

  task automatic test_back_to_back;
    int n;
    logic gap = 1'b0;
    send(5'd16, 3'b000, 3'b000, 8'd0);
    opr_code = 5'd8; src_typ = 3'b000; dst_typ = 3'b000; dst_code = 8'd0; instr_valid = 1'b1;
    total++; if ({alu_o_sel, alu_typ_sel, opr_typ_sel} !== {1'b0, 4'd0, 5'd16}) begin
      bad++; $display("FAIL jmp_sel got=%b/%0d/%0d exp=0/0/16", alu_o_sel, alu_typ_sel, opr_typ_sel); end
    for (int i = 0; i < 3; i++) begin
      if (!exec_busy) gap = 1'b1;
      @(negedge clk);
    end
    total++; if ({gap, exec_done, instr_ready} !== 3'b011) begin
      bad++; $display("FAIL jmp_done got=%b exp=011", {gap, exec_done, instr_ready}); end
    @(negedge clk);
    instr_valid = 1'b0;
    $display("txn op=8 back-to-back after op=16");
    total++; if ({exec_busy, alu_typ_sel, opr_typ_sel} !== {1'b1, 4'd6, 5'd8}) begin
      bad++; $display("FAIL inv_start got=%b/%0d/%0d exp=1/6/8", exec_busy, alu_typ_sel, opr_typ_sel); end
    count_busy(n);
    total++; if (n !== 21) begin bad++; $display("FAIL inv_busy_len got=%0d exp=21", n); end
    total++; if (exec_done !== 1'b1) begin bad++; $display("FAIL inv_done got=%b exp=1", exec_done); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic seen = 1'b0;
    send(5'd12, 3'b100, 3'b000, 8'd0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if ({exec_busy, exec_done, illegal, timeout, instr_ready} !== 5'b00001) begin
      bad++; $display("FAIL rstmid_status got=%b exp=00001", {exec_busy, exec_done, illegal, timeout, instr_ready}); end
    total++; if ({opr_typ_sel, alu_typ_sel, opr_div_mod_sel, alu_o_sel, alu_t_sel} !== 12'd0) begin
      bad++; $display("FAIL rstmid_sel got=%0d/%0d/%b/%b/%b exp=0/0/0/0/0",
                      opr_typ_sel, alu_typ_sel, opr_div_mod_sel, alu_o_sel, alu_t_sel); end
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (exec_done || exec_busy) seen = 1'b1;
      @(negedge clk);
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_done got=%b exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mov_sprf();
    test_idx();
    test_illegal();
    test_prng();
    test_div();
    test_mul_done();
    test_mul_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/opr_seq_decoder.md
OPR_SEQ_DECODER -- requirements
Module: opr_seq_decoder

Interface
REQ-001 SHALL have parameters (name, default, meaning): OPR_W, 5, opcode width; DST_W, 8, destination code width; DLY_W, 8, delay counter width; ALU_TYP_W, 4, ALU type width; PRNG_TYP_W, 2, PRNG type width; SPRF_N, 2, special registers; SPRF_BASE, 32, address of first special register; TMO_W, 12, wait-timeout counter width.
REQ-002 SHALL have ports (name, direction, width, meaning): clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-003 SHALL have ports: instr_valid in 1, instr_ready out 1, opr_code in OPR_W, dst_code in DST_W, src_typ in 3, dst_typ in 3, unit_done in 1 (variable-latency unit finished).
REQ-004 SHALL have ports: opr_typ_sel out OPR_W, opr_div_mod_sel out 1, alu_o_sel out 1, alu_t_sel out 1, alu_typ_sel out ALU_TYP_W, prng_t_sel out 1, prng_typ_sel out PRNG_TYP_W, sprf_typ_sel out 2*SPRF_N (2 bits per register, register k at [2k+1:2k]).
REQ-005 SHALL have ports: exec_busy out 1, exec_done out 1 (pulse), illegal out 1 (pulse), timeout out 1 (pulse).

Function
REQ-006 SHALL implement FSM IDLE, EXEC, WAIT_UNIT, DONE; instr_ready=1 only in IDLE and DONE; accept = instr_valid & instr_ready.
REQ-007 SHALL decode on accept and register all select outputs; values visible the cycle after accept, held stable through EXEC/WAIT_UNIT/DONE.
REQ-008 SHALL use delay D and selects: MOV(1): src/dst 101/000 or 101/100 D=6; 010/000, 000/000, 000/100 D=1; 000/101 D=2.
REQ-009 SHALL decode: ADD(2) alu_typ 1 D=4; SUB(3) 2 D=4; MUL(4) 3 var; DIV(5) 5 var; INV(8) 6 D=21; SPLIT(9) 2 var; DEG(10) 7 var; RSHIFT(11) 8 var; EVAL(12) 9 D=23; JRE(17) 4 D=7; all with alu_o_sel=alu_t_sel=1.
REQ-010 SHALL decode: JMP(16) alu selects 0, alu_typ 0, D=3; PRNG(6) 010/000 prng_t_sel=1 prng_typ 2 D=3; 000/000 prng_t_sel=0 prng_typ 1 D=4; IDX(7) dst_typ 000 D=2 code 2, dst_typ 001 D=2 code 3.
REQ-011 SHALL set opr_div_mod_sel=1 for DIV/EVAL iff src_typ==3'b100.
REQ-012 SHALL set sprf_typ_sel slot k to 1 for MOV 000/000, or the IDX code (2/3), when dst_code[4:0]==SPRF_BASE+k for k<SPRF_N; other slots 0.
REQ-013 SHALL treat any other opcode or typ combination as illegal: illegal=1 one cycle after accept, outputs unchanged, FSM returns to/stays IDLE.
REQ-014 EXEC SHALL load counter with D, decrement each cycle, go to DONE when counter==1; exec_busy=1 for exactly D cycles.
REQ-015 Variable ops SHALL enter WAIT_UNIT; go to DONE the cycle after unit_done=1; unit_done in other states ignored.
REQ-016 WAIT_UNIT SHALL count cycles; at 2^TMO_W-1 without unit_done, pulse timeout and go to DONE (exec_done also pulses).
REQ-017 DONE SHALL last one cycle with exec_done=1; an accept in DONE enters EXEC/WAIT_UNIT directly (back-to-back), else IDLE.
REQ-018 On return to IDLE, alu_o_sel, alu_t_sel, prng_t_sel, opr_div_mod_sel, sprf_typ_sel SHALL clear to 0; opr_typ_sel, alu_typ_sel, prng_typ_sel hold last value.

Reset
REQ-019 rst SHALL force IDLE, counters 0, all outputs 0 (instr_ready=1 on first cycle after rst), dominating any in-flight operation or accept.

Verification
REQ-020 ADD accept at T: alu_typ=1, selects=1 at T+1; exec_busy T+1..T+4; exec_done at T+5; ready at T+5.
REQ-021 MUL, unit_done at T+10: exec_done T+11; no unit_done: timeout+exec_done at T+1+4095.
REQ-022 MOV 000/000 dst_code=33: sprf_typ_sel=4'b0100, D=1; IDX dst_typ 001 dst 32: slot0=3, D=2.
REQ-023 opr_code=13 or PRNG 000/010: illegal pulse, no busy, previous outputs unchanged.
REQ-024 Back-to-back: JMP then INV valid held: INV accepted in JMP's DONE cycle, busy 21 cycles, no IDLE gap.
REQ-025 rst asserted mid-EVAL (counter 12): next cycle all outputs 0, IDLE, no exec_done.
